// File: rtl/fir_tap_pkg.sv
// fir_tap_pkg: shared FSM encoding, frame geometry helpers and burst address packing
package fir_tap_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_CMD, S_ACK, S_STREAM, S_PAD, S_FLUSH, S_DONE
    } state_e;

    function automatic int frame_words(input int burst_len, input int mem_bits, input int data_w);
        return burst_len * mem_bits / data_w;
    endfunction

    // One spare bit so the counter can hold FRAME_WORDS itself without wrapping
    function automatic int cnt_width(input int fw);
        return $clog2(fw) + 1;
    endfunction

    function automatic logic [31:0] pack_addr(input logic [15:0] line);
        return {16'd0, line};
    endfunction

endpackage

// File: rtl/fir_tap_vin_frame_gen.sv
// fir_tap_vin_frame_gen: turns a host tap stream into one zero-padded DDR burst frame
// framed by wr_cmd, with a handshake against the downstream buffer's idle flag.
module fir_tap_vin_frame_gen
    import fir_tap_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DATA_BITS = 256,
    parameter int BURST_LEN     = 128,
    parameter int ACK_TIMEOUT   = 64,
    localparam int FW           = frame_words(BURST_LEN, MEM_DATA_BITS, DATA_WIDTH),
    localparam int CNT_W        = cnt_width(FW)
) (
    input  logic                  ddr_clk_i,
    input  logic                  ddr_rst_i,
    input  logic                  tap_start_i,
    input  logic [15:0]           tap_line_i,
    input  logic [CNT_W-1:0]      tap_num_i,
    input  logic                  tap_vld_i,
    input  logic [DATA_WIDTH-1:0] tap_data_i,
    output logic                  tap_ready_o,
    input  logic                  ddr_fifo_full_i,
    input  logic                  ddr_wr_idle_i,
    output logic                  fir_tap_vld_o,
    output logic [DATA_WIDTH-1:0] fir_tap_data_o,
    output logic                  fir_tap_wr_cmd_o,
    output logic [31:0]           fir_tap_wr_addr_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [1:0]            err_o
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    state_e                state_q;
    logic [15:0]           line_q;
    logic [CNT_W-1:0]      num_q, num_d, cnt_q, cnt_d;
    logic [TMR_W-1:0]      timer_q;
    logic                  wr_cmd_q, vld_q, done_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            err_q;
    logic                  accept;

    // Zero or oversize requests take a full frame from the source with no padding
    assign num_d  = (tap_num_i == '0 || tap_num_i > CNT_W'(FW)) ? CNT_W'(FW) : tap_num_i;
    assign cnt_d  = cnt_q + CNT_W'(1);
    assign accept = tap_vld_i && tap_ready_o;

    assign tap_ready_o       = (state_q == S_STREAM) && (cnt_q < num_q);
    assign fir_tap_vld_o     = vld_q;
    assign fir_tap_data_o    = data_q;
    assign fir_tap_wr_cmd_o  = wr_cmd_q;
    assign fir_tap_wr_addr_o = pack_addr(line_q);
    assign busy_o            = state_q != S_IDLE;
    assign frame_done_o      = done_q;
    assign err_o             = err_q;

    always_ff @(posedge ddr_clk_i) begin
        if (ddr_rst_i) begin
            state_q  <= S_IDLE;
            line_q   <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            wr_cmd_q <= 1'b0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            if (tap_start_i && state_q != S_IDLE)
                err_q[0] <= 1'b1;
            case (state_q)
                S_IDLE: if (tap_start_i) begin
                    line_q  <= tap_line_i;
                    num_q   <= num_d;
                    state_q <= S_WAIT_RDY;
                end
                S_WAIT_RDY: if (ddr_wr_idle_i && !ddr_fifo_full_i)
                    state_q <= S_CMD;
                S_CMD: begin
                    wr_cmd_q <= 1'b1;
                    timer_q  <= '0;
                    cnt_q    <= '0;
                    state_q  <= S_ACK;
                end
                S_ACK: if (!ddr_wr_idle_i) begin
                    state_q <= S_STREAM;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    wr_cmd_q <= 1'b0;
                    err_q[1] <= 1'b1;
                    state_q  <= S_IDLE;
                end else begin
                    timer_q <= timer_q + TMR_W'(1);
                end
                S_STREAM: if (accept) begin
                    vld_q  <= 1'b1;
                    data_q <= tap_data_i;
                    cnt_q  <= cnt_d;
                    if (cnt_d == num_q)
                        state_q <= (num_q < CNT_W'(FW)) ? S_PAD : S_FLUSH;
                end
                // Padding never stalls: the buffer only drains once the whole frame is in
                S_PAD: begin
                    vld_q  <= 1'b1;
                    data_q <= '0;
                    cnt_q  <= cnt_d;
                    if (cnt_d == CNT_W'(FW))
                        state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    wr_cmd_q <= 1'b0;
                    if (ddr_wr_idle_i) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
